// File: rtl/niu32_pkg.sv
// niu32_pkg: shared definitions for the NIU32 sequencer.
//   - op1 opcode codes (IR[31:27]) and ALU function codes (op2 / alu_func)
//   - instruction class enum produced by niu32_op_class
//   - sequencer state encoding
//   - branch_func: maps a branch opcode to its compare ALU function
package niu32_pkg;

  // Primary opcodes (op1). The ALU-immediate opcodes share their value with
  // the ALU function they request, so the sequencer forwards op1 directly as
  // alu_func for that group.
  localparam logic [4:0] OP_ALUR = 5'd0;
  localparam logic [4:0] OP_ADDI = 5'd1;
  localparam logic [4:0] OP_SUBI = 5'd2;
  localparam logic [4:0] OP_ANDI = 5'd3;
  localparam logic [4:0] OP_ORI  = 5'd4;
  localparam logic [4:0] OP_XORI = 5'd5;
  localparam logic [4:0] OP_BEQ  = 5'd8;
  localparam logic [4:0] OP_BNE  = 5'd9;
  localparam logic [4:0] OP_BLT  = 5'd10;
  localparam logic [4:0] OP_BLE  = 5'd11;
  localparam logic [4:0] OP_LW   = 5'd16;
  localparam logic [4:0] OP_SW   = 5'd17;
  localparam logic [4:0] OP_LUI  = 5'd18;
  localparam logic [4:0] OP_JAL  = 5'd19;

  // ALU function codes
  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] ALU_SUB = 5'd2;
  localparam logic [4:0] ALU_AND = 5'd3;
  localparam logic [4:0] ALU_OR  = 5'd4;
  localparam logic [4:0] ALU_XOR = 5'd5;
  localparam logic [4:0] ALU_EQ  = 5'd8;
  localparam logic [4:0] ALU_NEQ = 5'd9;
  localparam logic [4:0] ALU_LT  = 5'd10;
  localparam logic [4:0] ALU_LEQ = 5'd11;

  typedef enum logic [2:0] {
    CLS_ALUR,
    CLS_ALUI,
    CLS_MEM,
    CLS_LUI,
    CLS_BRANCH,
    CLS_JAL,
    CLS_ILLEGAL
  } op_class_t;

  typedef enum logic [4:0] {
    ST_FETCH  = 5'd0,
    ST_DECODE = 5'd1,
    ST_ALU0R  = 5'd2,
    ST_ALU0I  = 5'd3,
    ST_ALU1   = 5'd4,
    ST_ALU2   = 5'd5,
    ST_MEM0   = 5'd6,
    ST_MEM1   = 5'd7,
    ST_MEM2   = 5'd8,
    ST_MEMW   = 5'd9,
    ST_LUI0   = 5'd10,
    ST_BR0    = 5'd11,
    ST_BR1    = 5'd12,
    ST_BR2    = 5'd13,
    ST_BR3    = 5'd14,
    ST_BR4    = 5'd15,
    ST_BR5    = 5'd16,
    ST_JAL0   = 5'd17,
    ST_JAL1   = 5'd18,
    ST_JAL2   = 5'd19,
    ST_JAL3   = 5'd20,
    ST_ERROR  = 5'd21
  } state_t;

  function automatic logic [4:0] branch_func(input logic [4:0] op);
    logic [4:0] f;
    case (op)
      OP_BEQ:  f = ALU_EQ;
      OP_BNE:  f = ALU_NEQ;
      OP_BLT:  f = ALU_LT;
      OP_BLE:  f = ALU_LEQ;
      default: f = 5'd0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/niu32_op_class.sv
// niu32_op_class: combinational decode of the primary opcode into an
// instruction class.
//   op1      in  OP_BITS  primary opcode IR[31:27]
//   op_class out          instruction class (op_class_t)
module niu32_op_class
  import niu32_pkg::*;
#(
  parameter int OP_BITS = 5
) (
  input  logic [OP_BITS-1:0] op1,
  output op_class_t          op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (op1)
      OP_BITS'(OP_ALUR): op_class = CLS_ALUR;
      OP_BITS'(OP_ADDI),
      OP_BITS'(OP_SUBI),
      OP_BITS'(OP_ANDI),
      OP_BITS'(OP_ORI),
      OP_BITS'(OP_XORI): op_class = CLS_ALUI;
      OP_BITS'(OP_LW),
      OP_BITS'(OP_SW):   op_class = CLS_MEM;
      OP_BITS'(OP_LUI):  op_class = CLS_LUI;
      OP_BITS'(OP_BEQ),
      OP_BITS'(OP_BNE),
      OP_BITS'(OP_BLT),
      OP_BITS'(OP_BLE):  op_class = CLS_BRANCH;
      OP_BITS'(OP_JAL):  op_class = CLS_JAL;
      default:           op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/niu32_seq_ctrl.sv
// niu32_seq_ctrl: multi-cycle Moore sequencer for the NIU32 datapath.
//   clk, reset(active-low, async)
//   op1/op2, rx/ry/rz   instruction fields from IR
//   alu_cond            ALU result bit 0 (branch compare outcome)
//   mem_ack             memory access complete
//   LdPC..DrALU         datapath load/drive strobes
//   reg_sel, alu_func   register selector and ALU function
//   mem_req             memory access request (held in MEMW)
//   state, error        debug state view, sticky illegal-opcode flag
module niu32_seq_ctrl
  import niu32_pkg::*;
#(
  parameter int STATE_BITS = 5,
  parameter int OP_BITS    = 5,
  parameter int REG_BITS   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OP_BITS-1:0]    op1,
  input  logic [OP_BITS-1:0]    op2,
  input  logic [REG_BITS-1:0]   rx,
  input  logic [REG_BITS-1:0]   ry,
  input  logic [REG_BITS-1:0]   rz,
  input  logic                  alu_cond,
  input  logic                  mem_ack,
  output logic                  LdPC,
  output logic                  DrPC,
  output logic                  IncPC,
  output logic                  LdIR,
  output logic                  LdMAR,
  output logic                  WrMem,
  output logic                  DrMem,
  output logic                  WrReg,
  output logic                  DrReg,
  output logic                  DrImm,
  output logic                  DrImmHi,
  output logic                  LdA,
  output logic                  LdB,
  output logic                  DrALU,
  output logic [REG_BITS-1:0]   reg_sel,
  output logic [OP_BITS-1:0]    alu_func,
  output logic                  mem_req,
  output logic [STATE_BITS-1:0] state,
  output logic                  error
);

  state_t    state_q, state_d;
  op_class_t op_class;

  niu32_op_class #(.OP_BITS(OP_BITS)) u_op_class (
    .op1      (op1),
    .op_class (op_class)
  );

  always_comb begin
    state_d  = state_q;
    LdPC     = 1'b0;
    DrPC     = 1'b0;
    IncPC    = 1'b0;
    LdIR     = 1'b0;
    LdMAR    = 1'b0;
    WrMem    = 1'b0;
    DrMem    = 1'b0;
    WrReg    = 1'b0;
    DrReg    = 1'b0;
    DrImm    = 1'b0;
    DrImmHi  = 1'b0;
    LdA      = 1'b0;
    LdB      = 1'b0;
    DrALU    = 1'b0;
    reg_sel  = '0;
    alu_func = '0;
    mem_req  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // Gated by reset so the FETCH strobes stay low while reset is held
        // (state_q is already FETCH then).
        LdIR    = reset;
        IncPC   = reset;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (op_class)
          CLS_ALUR:   state_d = ST_ALU0R;
          CLS_ALUI:   state_d = ST_ALU0I;
          CLS_MEM:    state_d = ST_MEM0;
          CLS_LUI:    state_d = ST_LUI0;
          CLS_BRANCH: state_d = ST_BR0;
          CLS_JAL:    state_d = ST_JAL0;
          default:    state_d = ST_ERROR;
        endcase
      end
      ST_ALU0R: begin
        reg_sel = ry;
        DrReg   = 1'b1;
        LdB     = 1'b1;
        state_d = ST_ALU1;
      end
      ST_ALU0I: begin
        DrImm   = 1'b1;
        LdB     = 1'b1;
        state_d = ST_ALU1;
      end
      ST_ALU1: begin
        reg_sel = rx;
        DrReg   = 1'b1;
        LdA     = 1'b1;
        state_d = ST_ALU2;
      end
      ST_ALU2: begin
        if (op_class == CLS_ALUR) begin
          alu_func = op2;
          reg_sel  = rz;
        end else begin
          alu_func = op1;
          reg_sel  = ry;
        end
        DrALU   = 1'b1;
        WrReg   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_MEM0: begin
        reg_sel = rx;
        DrReg   = 1'b1;
        LdA     = 1'b1;
        state_d = ST_MEM1;
      end
      ST_MEM1: begin
        DrImm   = 1'b1;
        LdB     = 1'b1;
        state_d = ST_MEM2;
      end
      ST_MEM2: begin
        alu_func = OP_BITS'(ALU_ADD);
        DrALU    = 1'b1;
        LdMAR    = 1'b1;
        state_d  = ST_MEMW;
      end
      ST_MEMW: begin
        mem_req = 1'b1;
        // Data transfer strobes only fire in the cycle the access completes.
        if (mem_ack) begin
          reg_sel = ry;
          if (op1 == OP_BITS'(OP_LW)) begin
            DrMem = 1'b1;
            WrReg = 1'b1;
          end else begin
            DrReg = 1'b1;
            WrMem = 1'b1;
          end
          state_d = ST_FETCH;
        end
      end
      ST_LUI0: begin
        reg_sel = ry;
        DrImmHi = 1'b1;
        WrReg   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_BR0: begin
        reg_sel = rx;
        DrReg   = 1'b1;
        LdA     = 1'b1;
        state_d = ST_BR1;
      end
      ST_BR1: begin
        reg_sel = ry;
        DrReg   = 1'b1;
        LdB     = 1'b1;
        state_d = ST_BR2;
      end
      ST_BR2: begin
        alu_func = OP_BITS'(branch_func(5'(op1)));
        state_d  = alu_cond ? ST_BR3 : ST_FETCH;
      end
      ST_BR3: begin
        // PC already incremented during FETCH: target = PC+1 + imm.
        DrPC    = 1'b1;
        LdA     = 1'b1;
        state_d = ST_BR4;
      end
      ST_BR4: begin
        DrImm   = 1'b1;
        LdB     = 1'b1;
        state_d = ST_BR5;
      end
      ST_BR5: begin
        alu_func = OP_BITS'(ALU_ADD);
        DrALU    = 1'b1;
        LdPC     = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_JAL0: begin
        reg_sel = ry;
        DrPC    = 1'b1;
        WrReg   = 1'b1;
        state_d = ST_JAL1;
      end
      ST_JAL1: begin
        reg_sel = rx;
        DrReg   = 1'b1;
        LdA     = 1'b1;
        state_d = ST_JAL2;
      end
      ST_JAL2: begin
        DrImm   = 1'b1;
        LdB     = 1'b1;
        state_d = ST_JAL3;
      end
      ST_JAL3: begin
        alu_func = OP_BITS'(ALU_ADD);
        DrALU    = 1'b1;
        LdPC     = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_ERROR: state_d = ST_ERROR;
      // Unused encodings are treated like an illegal opcode.
      default:  state_d = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  assign state = STATE_BITS'(state_q);
  assign error = (state_q == ST_ERROR);

endmodule

// File: tb/tb_niu32_seq_ctrl.sv
module tb_niu32_seq_ctrl;
  import niu32_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] op1, op2, rx, ry, rz;
  logic       alu_cond, mem_ack;
  logic       LdPC, DrPC, IncPC, LdIR, LdMAR, WrMem, DrMem, WrReg, DrReg;
  logic       DrImm, DrImmHi, LdA, LdB, DrALU;
  logic [4:0] reg_sel, alu_func, state;
  logic       mem_req, error;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [13:0] M_LDPC  = 14'd1 << 13;
  localparam logic [13:0] M_DRPC  = 14'd1 << 12;
  localparam logic [13:0] M_INCPC = 14'd1 << 11;
  localparam logic [13:0] M_LDIR  = 14'd1 << 10;
  localparam logic [13:0] M_LDMAR = 14'd1 << 9;
  localparam logic [13:0] M_WRMEM = 14'd1 << 8;
  localparam logic [13:0] M_DRMEM = 14'd1 << 7;
  localparam logic [13:0] M_WRREG = 14'd1 << 6;
  localparam logic [13:0] M_DRREG = 14'd1 << 5;
  localparam logic [13:0] M_DRIMM = 14'd1 << 4;
  localparam logic [13:0] M_DRIHI = 14'd1 << 3;
  localparam logic [13:0] M_LDA   = 14'd1 << 2;
  localparam logic [13:0] M_LDB   = 14'd1 << 1;
  localparam logic [13:0] M_DRALU = 14'd1 << 0;

  wire [13:0] strb = {LdPC, DrPC, IncPC, LdIR, LdMAR, WrMem, DrMem, WrReg,
                      DrReg, DrImm, DrImmHi, LdA, LdB, DrALU};
  wire [5:0]  bus  = {DrPC, DrMem, DrReg, DrImm, DrImmHi, DrALU};

  niu32_seq_ctrl #(.STATE_BITS(5), .OP_BITS(5), .REG_BITS(5)) dut (
    .clk(clk), .reset(reset), .op1(op1), .op2(op2), .rx(rx), .ry(ry), .rz(rz),
    .alu_cond(alu_cond), .mem_ack(mem_ack),
    .LdPC(LdPC), .DrPC(DrPC), .IncPC(IncPC), .LdIR(LdIR), .LdMAR(LdMAR),
    .WrMem(WrMem), .DrMem(DrMem), .WrReg(WrReg), .DrReg(DrReg), .DrImm(DrImm),
    .DrImmHi(DrImmHi), .LdA(LdA), .LdB(LdB), .DrALU(DrALU),
    .reg_sel(reg_sel), .alu_func(alu_func), .mem_req(mem_req),
    .state(state), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Bus-driver exclusivity monitor, active in every scenario.
  always @(negedge clk) begin
    check_eq("bus_onehot0", {31'd0, $onehot0(bus)}, 32'd1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Check all outputs of the current cycle, then advance one clock.
  task automatic expect_cyc(input string tag, input state_t st, input logic [13:0] s,
                            input logic [4:0] rs, input logic [4:0] af, input logic mr);
    #1;
    check_eq({tag, ".state"},    {27'd0, state},    {27'd0, st});
    check_eq({tag, ".strobes"},  {18'd0, strb},     {18'd0, s});
    check_eq({tag, ".reg_sel"},  {27'd0, reg_sel},  {27'd0, rs});
    check_eq({tag, ".alu_func"}, {27'd0, alu_func}, {27'd0, af});
    check_eq({tag, ".mem_req"},  {31'd0, mem_req},  {31'd0, mr});
    tick();
  endtask

  task automatic set_ir(input logic [4:0] o1, input logic [4:0] o2,
                        input logic [4:0] x, input logic [4:0] y, input logic [4:0] z);
    op1 = o1; op2 = o2; rx = x; ry = y; rz = z;
  endtask

  localparam logic [13:0] FETCH_S = M_LDIR | M_INCPC;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; alu_cond = 1'b0; mem_ack = 1'b0;
    set_ir(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst.state",   {27'd0, state},   32'd0);
    check_eq("rst.strobes", {18'd0, strb},    32'd0);
    check_eq("rst.mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst.error",   {31'd0, error},   32'd0);

    // ADD r3 = r1 + r2
    set_ir(5'd0, 5'd1, 5'd1, 5'd2, 5'd3);
    reset = 1'b1;
    expect_cyc("add.c1", ST_FETCH,  FETCH_S,          5'd0, 5'd0, 1'b0);
    expect_cyc("add.c2", ST_DECODE, 14'd0,            5'd0, 5'd0, 1'b0);
    expect_cyc("add.c3", ST_ALU0R,  M_DRREG | M_LDB,  5'd2, 5'd0, 1'b0);
    expect_cyc("add.c4", ST_ALU1,   M_DRREG | M_LDA,  5'd1, 5'd0, 1'b0);
    expect_cyc("add.c5", ST_ALU2,   M_DRALU | M_WRREG, 5'd3, 5'd1, 1'b0);

    // XORI r4 = r5 ^ imm: alu_func comes from op1
    set_ir(5'd5, 5'd0, 5'd5, 5'd4, 5'd9);
    expect_cyc("xori.c1", ST_FETCH,  FETCH_S,           5'd0, 5'd0, 1'b0);
    expect_cyc("xori.c2", ST_DECODE, 14'd0,             5'd0, 5'd0, 1'b0);
    expect_cyc("xori.c3", ST_ALU0I,  M_DRIMM | M_LDB,   5'd0, 5'd0, 1'b0);
    expect_cyc("xori.c4", ST_ALU1,   M_DRREG | M_LDA,   5'd5, 5'd0, 1'b0);
    expect_cyc("xori.c5", ST_ALU2,   M_DRALU | M_WRREG, 5'd4, 5'd5, 1'b0);

    // LW r7, imm(r6) with three wait cycles; a stray ack early is ignored
    set_ir(5'd16, 5'd0, 5'd6, 5'd7, 5'd0);
    mem_ack = 1'b1;
    expect_cyc("lw.c1", ST_FETCH,  FETCH_S,           5'd0, 5'd0, 1'b0);
    expect_cyc("lw.c2", ST_DECODE, 14'd0,             5'd0, 5'd0, 1'b0);
    expect_cyc("lw.c3", ST_MEM0,   M_DRREG | M_LDA,   5'd6, 5'd0, 1'b0);
    expect_cyc("lw.c4", ST_MEM1,   M_DRIMM | M_LDB,   5'd0, 5'd0, 1'b0);
    mem_ack = 1'b0;
    expect_cyc("lw.c5", ST_MEM2,   M_DRALU | M_LDMAR, 5'd0, 5'd1, 1'b0);
    expect_cyc("lw.c6", ST_MEMW,   14'd0,             5'd0, 5'd0, 1'b1);
    expect_cyc("lw.c7", ST_MEMW,   14'd0,             5'd0, 5'd0, 1'b1);
    expect_cyc("lw.c8", ST_MEMW,   14'd0,             5'd0, 5'd0, 1'b1);
    mem_ack = 1'b1;
    expect_cyc("lw.c9", ST_MEMW,   M_DRMEM | M_WRREG, 5'd7, 5'd0, 1'b1);
    mem_ack = 1'b0;

    // SW r8, imm(r2), ack on first MEMW cycle
    set_ir(5'd17, 5'd0, 5'd2, 5'd8, 5'd0);
    expect_cyc("sw.c1", ST_FETCH,  FETCH_S,           5'd0, 5'd0, 1'b0);
    expect_cyc("sw.c2", ST_DECODE, 14'd0,             5'd0, 5'd0, 1'b0);
    expect_cyc("sw.c3", ST_MEM0,   M_DRREG | M_LDA,   5'd2, 5'd0, 1'b0);
    expect_cyc("sw.c4", ST_MEM1,   M_DRIMM | M_LDB,   5'd0, 5'd0, 1'b0);
    expect_cyc("sw.c5", ST_MEM2,   M_DRALU | M_LDMAR, 5'd0, 5'd1, 1'b0);
    mem_ack = 1'b1;
    expect_cyc("sw.c6", ST_MEMW,   M_DRREG | M_WRMEM, 5'd8, 5'd0, 1'b1);
    mem_ack = 1'b0;

    // LUI r9
    set_ir(5'd18, 5'd0, 5'd0, 5'd9, 5'd0);
    expect_cyc("lui.c1", ST_FETCH,  FETCH_S,           5'd0, 5'd0, 1'b0);
    expect_cyc("lui.c2", ST_DECODE, 14'd0,             5'd0, 5'd0, 1'b0);
    expect_cyc("lui.c3", ST_LUI0,   M_DRIHI | M_WRREG, 5'd9, 5'd0, 1'b0);

    // BEQ not taken: five cycles, no LdPC
    set_ir(5'd8, 5'd0, 5'd1, 5'd2, 5'd0);
    alu_cond = 1'b0;
    expect_cyc("beqn.c1", ST_FETCH,  FETCH_S,         5'd0, 5'd0, 1'b0);
    expect_cyc("beqn.c2", ST_DECODE, 14'd0,           5'd0, 5'd0, 1'b0);
    expect_cyc("beqn.c3", ST_BR0,    M_DRREG | M_LDA, 5'd1, 5'd0, 1'b0);
    expect_cyc("beqn.c4", ST_BR1,    M_DRREG | M_LDB, 5'd2, 5'd0, 1'b0);
    expect_cyc("beqn.c5", ST_BR2,    14'd0,           5'd0, 5'd8, 1'b0);

    // BEQ taken: LdPC only in cycle 8
    alu_cond = 1'b1;
    expect_cyc("beqt.c1", ST_FETCH,  FETCH_S,           5'd0, 5'd0, 1'b0);
    expect_cyc("beqt.c2", ST_DECODE, 14'd0,             5'd0, 5'd0, 1'b0);
    expect_cyc("beqt.c3", ST_BR0,    M_DRREG | M_LDA,   5'd1, 5'd0, 1'b0);
    expect_cyc("beqt.c4", ST_BR1,    M_DRREG | M_LDB,   5'd2, 5'd0, 1'b0);
    expect_cyc("beqt.c5", ST_BR2,    14'd0,             5'd0, 5'd8, 1'b0);
    expect_cyc("beqt.c6", ST_BR3,    M_DRPC | M_LDA,    5'd0, 5'd0, 1'b0);
    expect_cyc("beqt.c7", ST_BR4,    M_DRIMM | M_LDB,   5'd0, 5'd0, 1'b0);
    expect_cyc("beqt.c8", ST_BR5,    M_DRALU | M_LDPC,  5'd0, 5'd1, 1'b0);
    alu_cond = 1'b0;

    // BLE not taken: compare function LEQ
    set_ir(5'd11, 5'd0, 5'd4, 5'd6, 5'd0);
    expect_cyc("ble.c1", ST_FETCH,  FETCH_S,         5'd0, 5'd0,  1'b0);
    expect_cyc("ble.c2", ST_DECODE, 14'd0,           5'd0, 5'd0,  1'b0);
    expect_cyc("ble.c3", ST_BR0,    M_DRREG | M_LDA, 5'd4, 5'd0,  1'b0);
    expect_cyc("ble.c4", ST_BR1,    M_DRREG | M_LDB, 5'd6, 5'd0,  1'b0);
    expect_cyc("ble.c5", ST_BR2,    14'd0,           5'd0, 5'd11, 1'b0);

    // JAL r31, imm(r3)
    set_ir(5'd19, 5'd0, 5'd3, 5'd31, 5'd0);
    expect_cyc("jal.c1", ST_FETCH,  FETCH_S,          5'd0,  5'd0, 1'b0);
    expect_cyc("jal.c2", ST_DECODE, 14'd0,            5'd0,  5'd0, 1'b0);
    expect_cyc("jal.c3", ST_JAL0,   M_DRPC | M_WRREG, 5'd31, 5'd0, 1'b0);
    expect_cyc("jal.c4", ST_JAL1,   M_DRREG | M_LDA,  5'd3,  5'd0, 1'b0);
    expect_cyc("jal.c5", ST_JAL2,   M_DRIMM | M_LDB,  5'd0,  5'd0, 1'b0);
    expect_cyc("jal.c6", ST_JAL3,   M_DRALU | M_LDPC, 5'd0,  5'd1, 1'b0);

    // Illegal opcode 5'b01100: ERROR is sticky until reset
    set_ir(5'b01100, 5'd0, 5'd0, 5'd0, 5'd0);
    expect_cyc("ill.c1", ST_FETCH,  FETCH_S, 5'd0, 5'd0, 1'b0);
    check_eq("ill.err_pre", {31'd0, error}, 32'd0);
    expect_cyc("ill.c2", ST_DECODE, 14'd0,   5'd0, 5'd0, 1'b0);
    mem_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check_eq("ill.error", {31'd0, error}, 32'd1);
      expect_cyc("ill.hold", ST_ERROR, 14'd0, 5'd0, 5'd0, 1'b0);
    end
    mem_ack = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("ill.rst_state", {27'd0, state}, 32'd0);
    check_eq("ill.rst_error", {31'd0, error}, 32'd0);
    check_eq("ill.rst_strb",  {18'd0, strb},  32'd0);
    tick();
    set_ir(5'd0, 5'd1, 5'd1, 5'd2, 5'd3);
    reset = 1'b1;
    expect_cyc("ill.rel", ST_FETCH,  FETCH_S, 5'd0, 5'd0, 1'b0);
    expect_cyc("ill.dec", ST_DECODE, 14'd0,   5'd0, 5'd0, 1'b0);
    expect_cyc("ill.alu", ST_ALU0R,  M_DRREG | M_LDB, 5'd2, 5'd0, 1'b0);
    expect_cyc("ill.alu1", ST_ALU1,  M_DRREG | M_LDA, 5'd1, 5'd0, 1'b0);
    expect_cyc("ill.alu2", ST_ALU2,  M_DRALU | M_WRREG, 5'd3, 5'd1, 1'b0);

    // Reset in MEMW: mem_req drops without waiting for a clock
    set_ir(5'd16, 5'd0, 5'd6, 5'd7, 5'd0);
    expect_cyc("rmw.c1", ST_FETCH,  FETCH_S,           5'd0, 5'd0, 1'b0);
    expect_cyc("rmw.c2", ST_DECODE, 14'd0,             5'd0, 5'd0, 1'b0);
    expect_cyc("rmw.c3", ST_MEM0,   M_DRREG | M_LDA,   5'd6, 5'd0, 1'b0);
    expect_cyc("rmw.c4", ST_MEM1,   M_DRIMM | M_LDB,   5'd0, 5'd0, 1'b0);
    expect_cyc("rmw.c5", ST_MEM2,   M_DRALU | M_LDMAR, 5'd0, 5'd1, 1'b0);
    #1;
    check_eq("rmw.memw_state", {27'd0, state},   {27'd0, ST_MEMW});
    check_eq("rmw.memw_req",   {31'd0, mem_req}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("rmw.rst_req",   {31'd0, mem_req}, 32'd0);
    check_eq("rmw.rst_state", {27'd0, state},   32'd0);
    check_eq("rmw.rst_strb",  {18'd0, strb},    32'd0);
    tick();
    reset = 1'b1;
    expect_cyc("rmw.rel", ST_FETCH,  FETCH_S, 5'd0, 5'd0, 1'b0);
    expect_cyc("rmw.dec", ST_DECODE, 14'd0,   5'd0, 5'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
